// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: instruction width,
//   default reset PC, the NOP presented to decode when the buffer is empty,
//   the buffered {pc, instr} entry layout and the fetch FSM state encoding.
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          ENTRY_W          = 2 * INSTR_W;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   // One buffered fetch result. pc occupies the upper half of the FIFO word.
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,   // first cycle after reset release
      S_REQ   = 2'd1,   // request presented (when buffer has room)
      S_WAIT  = 2'd2,   // request granted, waiting for its response
      S_DROP  = 2'd3    // response still owed but belongs to a flushed stream
   } fetch_state_e;

   // Instruction addresses are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched {pc, instr} pairs for decode.
//   The head entry is read directly from storage, so a push into an empty
//   FIFO is visible on head the following cycle.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     push         write push_data (ignored when full unless popping)
//     push_data    entry to write
//     pop          remove head (ignored when empty)
//     clear        drop every entry; has priority over push and pop
//     count        current number of entries (0..DEPTH)
//     empty        no entries
//     head         oldest entry (undefined content when empty)
// ----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic [WIDTH-1:0]         head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop && !empty;
   // Writing into a full FIFO is allowed when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; validity is tracked by count,
   // and leaving the array reset-free lets it map onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the PC, issues one word request at a time to a
//   variable-latency instruction memory, buffers responses as {pc, instr}
//   in fetch_fifo and offers them to decode over valid/ready. A redirect
//   from execute flushes the buffer, restarts at the new PC and discards any
//   response still owed for the old stream.
//   Optional feature macro: FETCH_STATS_EN adds stat_fetched / stat_flushed.
//   Ports:
//     clk, rst_n         clock / asynchronous active-low reset
//     imem_req/addr      fetch request (registered), held until imem_gnt
//     imem_gnt           request accepted
//     imem_rvalid/rdata  response for the accepted request
//     redirect_valid/pc  restart fetch at redirect_pc (low two bits ignored)
//     if_valid/ready     handshake toward decode
//     if_instr/pc        head instruction and its PC (0 when not valid)
//     if_pc_plus4        if_pc + 4 (0 when not valid)
//     stat_fetched       (FETCH_STATS_EN) pushes into the buffer
//     stat_flushed       (FETCH_STATS_EN) instructions discarded by redirects
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_pc_plus4
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        stat_fetched,
   output logic [31:0]        stat_flushed
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   fetch_state_e     state;
   logic [31:0]      fetch_pc;
   logic [31:0]      pend_pc;     // address of the request in flight
   logic             gnt_acc;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_n;
   logic             room_n;
   logic             fifo_empty;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   assign gnt_acc = imem_req && imem_gnt;
   // A response is only kept when it belongs to the live stream and no
   // redirect arrives in the same cycle.
   assign push    = (state == S_WAIT) && imem_rvalid && !redirect_valid;
   assign pop     = if_ready && !fifo_empty;

   assign push_entry.pc    = pend_pc;
   assign push_entry.instr = imem_rdata;

   // Occupancy after this edge. Requests are issued only in S_REQ, where
   // nothing is in flight, so room here guarantees the response fits.
   assign count_n = redirect_valid ? '0
                                   : fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign room_n  = (count_n < DEPTH_C);

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (redirect_valid),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head      (head)
   );

   // FSM, PC and the registered request. imem_req is computed from the
   // next state and next occupancy so it is glitch-free and, once raised in
   // S_REQ, stays high until granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RESET;
         fetch_pc <= word_align(RESET_PC);
         pend_pc  <= '0;
         imem_req <= 1'b0;
      end else begin
         if (redirect_valid) fetch_pc <= word_align(redirect_pc);
         else if (gnt_acc)   fetch_pc <= fetch_pc + 32'd4;

         if (gnt_acc) pend_pc <= fetch_pc;

         unique case (state)
            S_RESET: begin
               state    <= S_REQ;
               imem_req <= room_n;
            end
            S_REQ: begin
               if (gnt_acc) begin
                  // A grant coinciding with a redirect fetched a stale word.
                  state    <= redirect_valid ? S_DROP : S_WAIT;
                  imem_req <= 1'b0;
               end else begin
                  imem_req <= room_n;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state    <= S_REQ;
                  imem_req <= room_n;
               end else if (redirect_valid) begin
                  state    <= S_DROP;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  state    <= S_REQ;
                  imem_req <= room_n;
               end
            end
            default: begin
               state    <= S_RESET;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr = fetch_pc;

   // Decode sees zeros whenever the buffer is empty.
   assign if_valid    = !fifo_empty;
   assign if_instr    = if_valid ? head.instr        : NOP_INSTR;
   assign if_pc       = if_valid ? head.pc           : 32'h0;
   assign if_pc_plus4 = if_valid ? head.pc + 32'd4   : 32'h0;

`ifdef FETCH_STATS_EN
   // A redirect discards every buffered entry plus the owed response when the
   // in-flight request belonged to the live stream (S_WAIT, or granted in the
   // redirect cycle). In S_DROP that response was already counted.
   logic        resp_drop;
   logic [31:0] flush_amount;

   assign resp_drop    = (state == S_WAIT) || gnt_acc;
   assign flush_amount = 32'(fifo_count) + {31'b0, resp_drop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
      end else begin
         if (push)           stat_fetched <= stat_fetched + 32'd1;
         if (redirect_valid) stat_flushed <= stat_flushed + flush_amount;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. The bench plays the instruction
//   memory and the decode stage; a transaction-level model (next fetch
//   address, one owed response, queue of expected {pc, instr}) predicts what
//   decode must see each cycle. Inputs change on the falling edge, outputs
//   are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_flushed   (stat_flushed)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_pc = RST_PC;
   logic [31:0] pend_pc = '0;
   bit          outstanding = 1'b0;
   bit          dropped = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          pushes_total = 0;
   int          flushed_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Per-cycle expectations derived from the model state.
   task automatic check_outputs();
      check("if_valid", if_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check("if_pc", if_pc, exp_q[0].pc);
         check("if_instr", if_instr, exp_q[0].instr);
         check("if_pc_plus4", if_pc_plus4, exp_q[0].pc + 32'd4);
      end else begin
         check("if_instr_nop", if_instr, NOP_INSTR);
      end
      if (outstanding)          check("one_outstanding", imem_req, 1'b0);
      if (exp_q.size() == DEPTH) check("full_no_req", imem_req, 1'b0);
   endtask

   // One clock: drive inputs (called at a falling edge), update the model
   // for what the coming rising edge does, then sample at the next fall.
   task automatic cycle(input bit g, input bit r, input bit rdy, input bit redir,
                        input logic [31:0] rpc, input logic [31:0] data);
      bit accept;
      bit deliver;
      accept  = g && (imem_req === 1'b1);
      deliver = r && outstanding;
      imem_gnt       = accept;
      imem_rvalid    = deliver;
      imem_rdata     = data;
      if_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (accept) check("gnt_addr", imem_addr, model_pc);
      if (redir) begin
         flushed_total += exp_q.size() + (((outstanding && !dropped) || accept) ? 1 : 0);
         exp_q.delete();
         if (accept) begin
            outstanding = 1'b1;
            dropped     = 1'b1;
         end else if (deliver) begin
            outstanding = 1'b0;
            dropped     = 1'b0;
         end else if (outstanding) begin
            dropped = 1'b1;
         end
         model_pc = rpc & ~32'h3;
      end else begin
         if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
         if (deliver) begin
            if (!dropped) begin
               check("no_overflow", exp_q.size() < DEPTH, 1'b1);
               exp_q.push_back('{pc: pend_pc, instr: data});
               pushes_total++;
            end
            outstanding = 1'b0;
            dropped     = 1'b0;
         end
         if (accept) begin
            outstanding = 1'b1;
            dropped     = 1'b0;
            pend_pc     = model_pc;
            model_pc    = model_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      outstanding = 1'b0; dropped = 1'b0;
      model_pc = RST_PC; pend_pc = '0;
      pushes_total = 0; flushed_total = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, imem_req, 1'b0);
      check({tag, "_addr"}, imem_addr, RST_PC);
      check({tag, "_valid"}, if_valid, 1'b0);
      check({tag, "_instr"}, if_instr, 32'h0);
      check({tag, "_pc"}, if_pc, 32'h0);
      check({tag, "_pc_plus4"}, if_pc_plus4, 32'h0);
`ifdef FETCH_STATS_EN
      check({tag, "_stat_fetched"}, stat_fetched, 32'h0);
      check({tag, "_stat_flushed"}, stat_flushed, 32'h0);
`endif
   endtask

   initial begin
      int p0;
      // ---- reset values and first-fetch latency ----
      idle_inputs();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      model_reset();
      check("c0_req", imem_req, 1'b0);                  // S_RESET cycle
      cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
      check("c1_req", imem_req, 1'b1);
      check("c1_addr", imem_addr, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);            // granted in cycle 1
      cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 32'h1111_0000); // push in cycle 2
      check("c3_valid", if_valid, 1'b1);
      check("c3_pc", if_pc, 32'h0);

      // ---- streaming with decode always ready ----
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, $urandom);

      // ---- decode stall: exactly DEPTH pushes, then requests stop ----
      repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, $urandom);
      check("idle_req", imem_req, 1'b1);
      p0 = pushes_total;
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, $urandom);
      check("stall_pushes", pushes_total - p0, DEPTH);
      check("stall_req_low", imem_req, 1'b0);
      repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, $urandom);

      // ---- redirect while waiting; late response is dropped ----
      check("pre_redir_req", imem_req, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, '0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 32'h0000_DEAD);
      check("drop_valid", if_valid, 1'b0);
      check("redir_addr", imem_addr, 32'h0000_0100);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h1234_5678);
      check("redir_pc", if_pc, 32'h0000_0100);
      check("redir_instr", if_instr, 32'h1234_5678);

      // ---- unaligned redirect target ----
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0203, '0);
      check("align_addr", imem_addr, 32'h0000_0200);

      // ---- PC wrap ----
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, '0);
      p0 = pushes_total;
      for (int i = 0; i < 20 && (pushes_total - p0) < 2; i++)
         cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, $urandom);
      check("wrap_fetches", pushes_total - p0, 2);
      check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
      check("wrap_plus4_0", if_pc_plus4, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      check("wrap_pc1", if_pc, 32'h0);
      check("wrap_plus4_1", if_pc_plus4, 32'h4);

      // ---- randomized traffic with occasional redirects ----
      for (int i = 0; i < 1500; i++) begin
         bit          redir;
         logic [31:0] tgt;
         redir = ($urandom_range(0, 31) == 0);
         tgt   = $urandom_range(0, 1) ? 32'(32'hFFFF_FFF0 + $urandom_range(0, 15)) : 32'($urandom);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 3) != 0, redir, tgt, $urandom);
      end
`ifdef FETCH_STATS_EN
      check("stat_fetched", stat_fetched, pushes_total);
      check("stat_flushed", stat_flushed, flushed_total);
`endif

      // ---- asynchronous reset in the middle of S_WAIT ----
      repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, $urandom);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'hCAFE_0001);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);            // now in S_WAIT, one entry buffered
      check("pre_rst_valid", if_valid, 1'b1);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("post_rst_req", imem_req, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      check("post_rst_req1", imem_req, 1'b1);
      check("post_rst_addr", imem_addr, RST_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
